// File: rtl/booth_mult.sv
// Sequential radix-2 Booth signed multiplier; the A+/-M step is performed by an
// external addsub instance wired to the add_* ports and read back via add_result.
module booth_mult #(
  parameter int dw = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [dw-1:0]     multiplicand,
  input  logic [dw-1:0]     multiplier,
  output logic              busy,
  output logic              done,
  output logic [2*dw-1:0]   product,
  output logic [dw:0]       add_a,
  output logic [dw:0]       add_b,
  output logic              add_sub,
  input  logic [dw:0]       add_result
);

  localparam int CW = $clog2(dw + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [dw:0]         a_q, a_d;
  logic [dw-1:0]       q_q, q_d;
  logic                q1_q, q1_d;
  logic [dw-1:0]       m_q, m_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*dw-1:0]     prod_q, prod_d;
  logic [dw:0]         sum;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    sum     = a_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = '0;
          q_d     = multiplier;
          q1_d    = 1'b0;
          m_d     = multiplicand;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        case ({q_q[0], q1_q})
          2'b01, 2'b10: sum = add_result;
          default:      sum = a_q;
        endcase
        // Arithmetic shift of {sum, Q, Q_1}: the old Q_1 falls off the end.
        {a_d, q_d, q1_d} = {sum[dw], sum, q_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(dw - 1)) begin
          prod_d  = {a_d[dw-1:0], q_d};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = prod_q;
  assign add_a   = a_q;
  assign add_b   = {m_q[dw-1], m_q};
  assign add_sub = !((state_q == CALC) && ({q_q[0], q1_q} == 2'b10));

endmodule
